xmem_fifo_responder: RTL and testbench

- Responder on the AVR external data-memory window: the device side of the sram_cs/oe/we/wait bus driven by the core's interconnect.
- Provides a byte scratch RAM plus four control registers at the top of the window, with one uniform read wait state.
- Feeds a byte FIFO that drains to a downstream valid/ready stream.
- Stalls the core through sram_wait when it writes to a full FIFO.

---
 rtl/xmem_pkg.sv | 31 +++
 rtl/xmem_sync_fifo.sv | 58 +++++
 rtl/xmem_fifo_responder.sv | 197 +++++++++++++++++++
 tb/tb_xmem_fifo_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmem_pkg.sv
// Shared definitions for the external-memory FIFO responder.
//   - Register offsets, measured downward from the top of the window
//   - STATUS / CTRL bit positions
//   - Read-FSM state type
//   - Saturating byte conversion used for the LEVEL register
package xmem_pkg;

  localparam int unsigned REG_STATUS = 4;
  localparam int unsigned REG_DATA   = 3;
  localparam int unsigned REG_LEVEL  = 2;
  localparam int unsigned REG_CTRL   = 1;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;
  localparam int unsigned ST_IRQ   = 3;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_IEN     = 1;
  localparam int unsigned CTRL_OVF_CLR = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DONE = 1'b1
  } rd_state_t;

  function automatic logic [7:0] sat_u8(input int unsigned v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

endpackage

// File: rtl/xmem_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write request and data (ignored when full unless popping)
//   pop, dout     : read request and head-of-queue data
//   flush         : empties the FIFO; wins over a same-cycle push
//   full, empty   : occupancy flags
//   level         : number of stored entries
module xmem_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign level = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop) & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/xmem_fifo_responder.sv
// Device-side responder on the AVR external data-memory window.
// Scratch RAM in the lower window, STATUS/DATA/LEVEL/CTRL at the top,
// one read wait state, and a byte FIFO drained to a valid/ready stream.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   sram_a, sram_d_out, sram_d_in   : address, write data, read data
//   sram_cs, sram_oe, sram_we       : select and strobes
//   sram_wait                       : stalls the core while high
//   st_data, st_valid, st_ready     : outgoing byte stream
//   irq                             : level interrupt (FIFO at/below IRQ_LEVEL)
// Optional: define XMEM_FIFO_TIMEOUT_EN to bound full-FIFO stalls to
// TIMEOUT cycles, dropping the write and flagging overflow.
module xmem_fifo_responder
  import xmem_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hE000,
  parameter int unsigned WIN_SIZE   = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_LEVEL  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sram_a,
  input  logic [7:0]  sram_d_out,
  output logic [7:0]  sram_d_in,
  input  logic        sram_cs,
  input  logic        sram_oe,
  input  logic        sram_we,
  output logic        sram_wait,
  output logic [7:0]  st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(WIN_SIZE);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] OFF_STATUS = AW'(WIN_SIZE - REG_STATUS);
  localparam logic [AW-1:0] OFF_DATA   = AW'(WIN_SIZE - REG_DATA);
  localparam logic [AW-1:0] OFF_LEVEL  = AW'(WIN_SIZE - REG_LEVEL);
  localparam logic [AW-1:0] OFF_CTRL   = AW'(WIN_SIZE - REG_CTRL);

  rd_state_t     r_state;
  rd_state_t     w_state_next;
  logic [AW-1:0] w_off;
  logic          w_is_ram;
  logic          w_rd;
  logic          w_wr;
  logic          w_rd_issue;
  logic          w_ram_wr;
  logic          w_data_wr;
  logic          w_ctrl_wr;
  logic          w_pop;
  logic          w_push;
  logic          w_flush;
  logic          w_blocked;
  logic          w_stall;
  logic          w_tmo;
  logic          w_ovf;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [7:0]    w_head;
  logic [7:0]    w_rdata;
  logic [7:0]    w_status;
  logic [7:0]    r_d_in;
  logic          r_ien;
  logic          r_irq;
  logic [7:0]    r_mem [WIN_SIZE];

  // Window is aligned, so subtracting the base only keeps the low bits.
  assign w_off    = AW'(sram_a - BASE_ADDR);
  assign w_is_ram = (32'(w_off) < (WIN_SIZE - 4));
  assign w_rd     = sram_cs & sram_oe;
  assign w_wr     = sram_cs & sram_we;
  assign w_ram_wr  = w_wr & w_is_ram;
  assign w_data_wr = w_wr & (w_off == OFF_DATA);
  assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
  assign w_flush   = w_ctrl_wr & sram_d_out[CTRL_FLUSH];

  assign w_pop     = ~w_empty & st_ready;
  assign w_blocked = w_full & ~w_pop;
  assign w_stall   = w_data_wr & w_blocked & ~w_tmo;
  assign w_push    = w_data_wr & ~w_blocked;

`ifdef XMEM_FIFO_TIMEOUT_EN
  logic [7:0] r_stall_cnt;
  logic       r_ovf;

  // Terminal count releases wait for one cycle and drops the write.
  assign w_tmo = w_data_wr & w_blocked & (r_stall_cnt == 8'(TIMEOUT));
  assign w_ovf = r_ovf;

  always_ff @(posedge clk) begin
    if (rst)          r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 8'd1;
    else              r_stall_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)                                       r_ovf <= 1'b0;
    else if (w_tmo)                                r_ovf <= 1'b1;
    else if (w_ctrl_wr && sram_d_out[CTRL_OVF_CLR]) r_ovf <= 1'b0;
  end
`else
  logic w_unused_timeout;
  assign w_tmo            = 1'b0;
  assign w_ovf            = 1'b0;
  assign w_unused_timeout = ^8'(TIMEOUT);
`endif

  xmem_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (sram_d_out),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign st_valid = ~w_empty;
  assign st_data  = w_empty ? '0 : w_head;

  always_ff @(posedge clk) begin
    if (w_ram_wr) r_mem[w_off] <= sram_d_out;
  end

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = w_ovf;
    w_status[ST_IRQ]   = r_irq;
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ram) begin
      w_rdata = r_mem[w_off];
    end else begin
      case (w_off)
        OFF_STATUS: w_rdata = w_status;
        OFF_LEVEL:  w_rdata = sat_u8(32'(w_level));
        OFF_CTRL:   w_rdata = {6'b0, r_ien, 1'b0};
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_issue   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rd) begin
          w_rd_issue   = 1'b1;
          w_state_next = RD_DONE;
        end
      end
      RD_DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign sram_wait = ~rst & (w_rd_issue | w_stall);

  always_ff @(posedge clk) begin
    if (rst)             r_d_in <= '0;
    else if (w_rd_issue) r_d_in <= w_rdata;
  end
  assign sram_d_in = r_d_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ien <= sram_d_out[CTRL_IEN];
      r_irq <= r_ien & (32'(w_level) <= IRQ_LEVEL);
    end
  end
  assign irq = r_irq;

endmodule

// File: tb/tb_xmem_fifo_responder.sv
module tb_xmem_fifo_responder;

  localparam logic [15:0] BASE     = 16'hE000;
  localparam logic [9:0]  O_STATUS = 10'h3FC;
  localparam logic [9:0]  O_DATA   = 10'h3FD;
  localparam logic [9:0]  O_LEVEL  = 10'h3FE;
  localparam logic [9:0]  O_CTRL   = 10'h3FF;
  localparam int          LIMIT    = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sram_a = '0;
  logic [7:0]  sram_d_out = '0;
  logic [7:0]  sram_d_in;
  logic        sram_cs = 1'b0;
  logic        sram_oe = 1'b0;
  logic        sram_we = 1'b0;
  logic        sram_wait;
  logic [7:0]  st_data;
  logic        st_valid;
  logic        st_ready = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];

  typedef struct {
    bit         wr;
    logic [9:0] off;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[19];

  xmem_fifo_responder #(
    .BASE_ADDR  (16'hE000),
    .WIN_SIZE   (1024),
    .FIFO_DEPTH (16),
    .IRQ_LEVEL  (4),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_a     (sram_a),
    .sram_d_out (sram_d_out),
    .sram_d_in  (sram_d_in),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .sram_wait  (sram_wait),
    .st_data    (st_data),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic wr(input logic [9:0] off, input logic [7:0] d, output int w);
    sram_a = BASE + 16'(off); sram_d_out = d; sram_cs = 1'b1; sram_we = 1'b1;
    w = 0;
    #3;
    while (sram_wait && w < LIMIT) begin
      w++;
      @(posedge clk);
      #4;
    end
    if (off == O_DATA) q.push_back(d);
    tick;
    sram_cs = 1'b0; sram_we = 1'b0;
    tick;
  endtask

  task automatic rd(input logic [9:0] off, output logic [7:0] d, output int w);
    sram_a = BASE + 16'(off); sram_cs = 1'b1; sram_oe = 1'b1;
    w = 0;
    #3;
    while (sram_wait && w < LIMIT) begin
      w++;
      @(posedge clk);
      #4;
    end
    d = sram_d_in;
    tick;
    sram_cs = 1'b0; sram_oe = 1'b0;
    tick;
  endtask

  task automatic wr_chk(input logic [9:0] off, input logic [7:0] d);
    int w;
    wr(off, d, w);
    chk("wr_waits", 32'(w), 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [9:0] off, input logic [7:0] exp);
    int w;
    logic [7:0] d;
    rd(off, d, w);
    chk({name, "_waits"}, 32'(w), 32'd1);
    chk(name, 32'(d), 32'(exp));
  endtask

  // Stream scoreboard: every accepted byte must match the oldest pushed byte.
  always @(negedge clk) begin
    if (!rst && st_valid && st_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got %0h expected no byte", st_data);
      end else begin
        chk("stream_data", 32'(st_data), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 10'h010, 8'h5A};
    tbl[1]  = '{1'b0, 10'h010, 8'h5A};
    tbl[2]  = '{1'b1, 10'h000, 8'h11};
    tbl[3]  = '{1'b1, 10'h3FB, 8'hEE};
    tbl[4]  = '{1'b0, 10'h000, 8'h11};
    tbl[5]  = '{1'b0, 10'h3FB, 8'hEE};
    tbl[6]  = '{1'b0, O_STATUS, 8'h01};
    tbl[7]  = '{1'b0, O_DATA,   8'h00};
    tbl[8]  = '{1'b0, O_LEVEL,  8'h00};
    tbl[9]  = '{1'b0, O_CTRL,   8'h00};
    tbl[10] = '{1'b1, O_CTRL,   8'h02};
    tbl[11] = '{1'b0, O_CTRL,   8'h02};
    tbl[12] = '{1'b0, O_STATUS, 8'h09};
    tbl[13] = '{1'b1, O_CTRL,   8'h00};
    tbl[14] = '{1'b1, O_STATUS, 8'hFF};
    tbl[15] = '{1'b1, O_LEVEL,  8'h55};
    tbl[16] = '{1'b0, O_STATUS, 8'h01};
    tbl[17] = '{1'b0, O_LEVEL,  8'h00};
    tbl[18] = '{1'b0, 10'h010,  8'h5A};

    // Reset values
    repeat (3) @(posedge clk);
    #4;
    chk("rst_d_in", 32'(sram_d_in), 32'h0);
    chk("rst_wait", 32'(sram_wait), 32'h0);
    chk("rst_valid", 32'(st_valid), 32'h0);
    chk("rst_st_data", 32'(st_data), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    tick;

    // RAM and register access table
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].wr) wr_chk(tbl[i].off, tbl[i].data);
      else           rd_chk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].data);
    end

    // Three bytes queued, then drained on consecutive cycles
    st_ready = 1'b0;
    wr_chk(O_DATA, 8'hA1);
    wr_chk(O_DATA, 8'hB2);
    wr_chk(O_DATA, 8'hC3);
    rd_chk("level3", O_LEVEL, 8'h03);
    rd_chk("status3", O_STATUS, 8'h00);
    st_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3 chk("drain_valid", 32'(st_valid), 32'h1);
      tick;
    end
    #3 chk("drain_done", 32'(st_valid), 32'h0);
    st_ready = 1'b0;
    tick;
    rd_chk("status_empty", O_STATUS, 8'h01);

    // Full FIFO stall for 10 cycles, released by a single pop
    for (int i = 0; i < 16; i++) wr_chk(O_DATA, 8'(i * 7 + 3));
    rd_chk("status_full", O_STATUS, 8'h02);
    rd_chk("level_full", O_LEVEL, 8'h10);
    sram_a = BASE + 16'(O_DATA); sram_d_out = 8'h77; sram_cs = 1'b1; sram_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #3 chk("stall_wait", 32'(sram_wait), 32'h1);
      tick;
    end
    st_ready = 1'b1;
    #3 chk("stall_release", 32'(sram_wait), 32'h0);
    q.push_back(8'h77);
    tick;
    st_ready = 1'b0; sram_cs = 1'b0; sram_we = 1'b0;
    tick;
    rd_chk("level_after_stall", O_LEVEL, 8'h10);
    st_ready = 1'b1;
    repeat (16) tick;
    st_ready = 1'b0;
    #3 chk("drain16_valid", 32'(st_valid), 32'h0);
    chk("drain16_queue", 32'(q.size()), 32'h0);
    tick;

    // irq threshold and flush
    wr_chk(O_CTRL, 8'h02);
    for (int i = 0; i < 5; i++) wr_chk(O_DATA, 8'(8'h40 + i));
    chk("irq_level5", 32'(irq), 32'h0);
    rd_chk("level5", O_LEVEL, 8'h05);
    st_ready = 1'b1;
    tick;
    st_ready = 1'b0;
    #3 chk("irq_lag", 32'(irq), 32'h0);
    tick;
    #3 chk("irq_level4", 32'(irq), 32'h1);
    tick;
    wr_chk(O_CTRL, 8'h03);
    q.delete();
    chk("flush_valid", 32'(st_valid), 32'h0);
    rd_chk("flush_level", O_LEVEL, 8'h00);
    rd_chk("flush_ctrl", O_CTRL, 8'h02);

    // Reset during a read wait cycle
    wr_chk(O_DATA, 8'h31);
    wr_chk(O_DATA, 8'h32);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    sram_a = BASE + 16'(O_CTRL); sram_cs = 1'b1; sram_oe = 1'b1;
    #3 chk("rd_wait_before_rst", 32'(sram_wait), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0; sram_cs = 1'b0; sram_oe = 1'b0;
    q.delete();
    #3;
    chk("rst_rd_wait", 32'(sram_wait), 32'h0);
    chk("rst_rd_valid", 32'(st_valid), 32'h0);
    chk("rst_rd_irq", 32'(irq), 32'h0);
    chk("rst_rd_d_in", 32'(sram_d_in), 32'h0);
    tick;
    rd_chk("rst_rd_level", O_LEVEL, 8'h00);

    // Reset during a full stall
    for (int i = 0; i < 16; i++) wr_chk(O_DATA, 8'(8'h80 + i));
    sram_a = BASE + 16'(O_DATA); sram_d_out = 8'h99; sram_cs = 1'b1; sram_we = 1'b1;
    #3 chk("stall_before_rst", 32'(sram_wait), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0; sram_cs = 1'b0; sram_we = 1'b0;
    q.delete();
    #3;
    chk("rst_stall_wait", 32'(sram_wait), 32'h0);
    chk("rst_stall_valid", 32'(st_valid), 32'h0);
    chk("rst_stall_irq", 32'(irq), 32'h0);
    tick;
    rd_chk("rst_stall_level", O_LEVEL, 8'h00);
    rd_chk("rst_stall_status", O_STATUS, 8'h01);
    rd_chk("rst_stall_ctrl", O_CTRL, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
